// File: rtl/spi_slave_param.sv
// ---------------------------------------------------------------------------
// spi_slave_param
//   Parametrised SPI slave between an external SPI master and a RAM
//   controller. Frames are one mode bit (0 = write, 1 = read) followed by
//   DATA_W+2 bits {cmd[1:0], payload}, shifted in MSB first. Read frames
//   alternate between "read address" and "read data"; a read-data frame is
//   followed by a reply phase that serialises tx_data onto MISO.
//
//   Optional feature macro: SPI_SLV_FRAME_ERR_EN
//     When defined, the frame_err output pulses for one cycle whenever SS_n
//     rises before a frame or reply has completed.
//
// Ports
//   clk        SPI clock; all I/O sampled/driven on the rising edge
//   rst        synchronous active-high reset
//   SS_n       slave select, active-low; high ends or aborts a frame
//   MOSI       serial data from master
//   MISO       serial data to master (registered)
//   rx_data    received {cmd, payload}, valid while rx_valid is high
//   rx_valid   one-cycle pulse per completed frame
//   tx_data    read data from RAM controller
//   tx_valid   tx_data qualifier, only looked at while waiting for data
//   frame_err  (SPI_SLV_FRAME_ERR_EN only) abort pulse
// ---------------------------------------------------------------------------
module spi_slave_param #(
  parameter int DATA_W       = 8,
  parameter bit TX_MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
`ifdef SPI_SLV_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 3);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RD_WAIT, RD_TX, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W+1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                miso_q, miso_d;
  logic                rd_addr_seen_q, rd_addr_seen_d;
  logic [DATA_W-1:0]   tx_q, tx_d;

  // First bit of a fresh word, the rest of it, and the next bit / shift
  // of the word already in the TX register, for the selected bit order.
  logic                tx_first_bit;
  logic [DATA_W-1:0]   tx_first_rest;
  logic                tx_next_bit;
  logic [DATA_W-1:0]   tx_next_rest;

  always_comb begin
    if (TX_MSB_FIRST) begin
      tx_first_bit  = tx_data[DATA_W-1];
      tx_first_rest = tx_data << 1;
      tx_next_bit   = tx_q[DATA_W-1];
      tx_next_rest  = tx_q << 1;
    end else begin
      tx_first_bit  = tx_data[0];
      tx_first_rest = tx_data >> 1;
      tx_next_bit   = tx_q[0];
      tx_next_rest  = tx_q >> 1;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = miso_q;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_d           = tx_q;

    // Deselect wins over everything, including the edge that would have
    // captured the last bit of a frame.
    if (state_q != IDLE && SS_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d  = '0;
          miso_d = 1'b0;
          if (!SS_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          cnt_d = '0;
          if (MOSI) state_d = rd_addr_seen_q ? READ_DATA : READ_ADD;
          else      state_d = WRITE;
        end
        WRITE, READ_ADD, READ_DATA: begin
          rx_data_d = {rx_data_q[DATA_W:0], MOSI};
          if (cnt_q == LAST_RX) begin
            cnt_d      = '0;
            rx_valid_d = 1'b1;
            if (state_q == READ_DATA) begin
              state_d        = RD_WAIT;
              rd_addr_seen_d = 1'b0;
            end else begin
              state_d = DONE;
              if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RD_WAIT: begin
          if (tx_valid) begin
            miso_d  = tx_first_bit;
            tx_d    = tx_first_rest;
            cnt_d   = CNT_W'(1);   // counts bits already placed on MISO
            state_d = RD_TX;
          end
        end
        RD_TX: begin
          if (cnt_q == LAST_TX) begin
            miso_d  = 1'b0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            miso_d = tx_next_bit;
            tx_d   = tx_next_rest;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_q           <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_q           <= tx_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLV_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  // Only states that are part-way through a frame or reply report an abort.
  always_comb begin
    frame_err_d = 1'b0;
    if (SS_n && (state_q == CHK_CMD || state_q == WRITE || state_q == READ_ADD ||
                 state_q == READ_DATA || state_q == RD_WAIT || state_q == RD_TX))
      frame_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
module tb_spi_slave_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_valid;

  logic       miso_m, miso_l;
  logic [9:0] rx_data_m, rx_data_l;
  logic       rx_valid_m, rx_valid_l;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic       ferr_m, ferr_l;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .TX_MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_m),
    .rx_data(rx_data_m), .rx_valid(rx_valid_m),
    .tx_data(tx_data), .tx_valid(tx_valid)
`ifdef SPI_SLV_FRAME_ERR_EN
    , .frame_err(ferr_m)
`endif
  );

  spi_slave_param #(.DATA_W(8), .TX_MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_l),
    .rx_data(rx_data_l), .rx_valid(rx_valid_l),
    .tx_data(tx_data), .tx_valid(tx_valid)
`ifdef SPI_SLV_FRAME_ERR_EN
    , .frame_err(ferr_l)
`endif
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rx_valid pulse must match the oldest pending frame.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && (rx_valid_m || rx_valid_l)) begin
      check_bit("rx_valid_pair", rx_valid_l, rx_valid_m);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL rx_unexpected: got pulse data 0x%0h expected no pulse at %0t",
                 rx_data_m, $time);
      end else begin
        e = exp_q.pop_front();
        check_vec("rx_data_msb_inst", 32'(rx_data_m), 32'(e));
        check_vec("rx_data_lsb_inst", 32'(rx_data_l), 32'(e));
        $display("[TB] rx frame 0x%03h (expected 0x%03h)", rx_data_m, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select, mode bit, then 10 frame bits MSB first. MISO must stay low throughout.
  task automatic send_frame(input logic mode, input logic [9:0] bits, input bit expect_rx);
    if (expect_rx) exp_q.push_back(bits);
    ss_n = 1'b0;
    mosi = 1'b0;
    tick();
    mosi = mode;
    tick();
    for (int i = 9; i >= 0; i--) begin
      mosi = bits[i];
      tick();
      check_bit("miso_low_in_frame", miso_m, 1'b0);
    end
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    tick();
    tick();
  endtask

  // Reply phase: capture tx, then 8 data bits, then MISO back to 0.
  task automatic reply(input logic [7:0] tx);
    tx_data  = tx;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~tx;   // must not be recaptured
    for (int k = 0; k < 8; k++) begin
      check_bit("miso_msb_first", miso_m, tx[7-k]);
      check_bit("miso_lsb_first", miso_l, tx[k]);
      tick();
    end
    check_bit("miso_after_reply_m", miso_m, 1'b0);
    check_bit("miso_after_reply_l", miso_l, 1'b0);
    $display("[TB] reply 0x%02h serialised", tx);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) tick();
    check_bit("reset_miso", miso_m, 1'b0);
    check_bit("reset_rx_valid", rx_valid_m, 1'b0);
    check_vec("reset_rx_data", 32'(rx_data_m), 32'h0);
    check_bit("reset_rd_addr_seen", dut_m.rd_addr_seen_q, 1'b0);
`ifdef SPI_SLV_FRAME_ERR_EN
    check_bit("reset_frame_err", ferr_m, 1'b0);
`endif
    rst = 1'b0;
    tick();

    // Write frame with tx_valid held high (must be ignored).
    tx_valid = 1'b1; tx_data = 8'hFF;
    send_frame(1'b0, 10'b00_1010_0101, 1'b1);
    // Extra bits while still selected: DONE ignores them, no second pulse.
    for (int i = 0; i < 12; i++) begin
      mosi = i[0];
      tick();
      check_bit("miso_low_done", miso_m, 1'b0);
    end
    tx_valid = 1'b0;
    check_vec("write_rx_data_hold", 32'(rx_data_m), 32'h0A5);
    end_frame();
    check_bit("write_keeps_flag_clear", dut_m.rd_addr_seen_q, 1'b0);
    $display("[TB] write frame done");

    // Read pair, reply C3.
    send_frame(1'b1, 10'h203, 1'b1);
    tick();
    check_bit("rd_addr_seen_set", dut_m.rd_addr_seen_q, 1'b1);
    end_frame();
    send_frame(1'b1, 10'h300, 1'b1);
    tick();
    check_bit("rd_addr_seen_cleared", dut_m.rd_addr_seen_q, 1'b0);
    tick();
    check_bit("miso_wait", miso_m, 1'b0);
    reply(8'hC3);
    end_frame();

    // Second read pair, reply 01 (distinguishes bit orders).
    send_frame(1'b1, 10'h205, 1'b1);
    end_frame();
    send_frame(1'b1, 10'h3AA, 1'b1);
    tick();
    reply(8'h01);
    end_frame();

    // Abort after 5 payload bits of a read-data frame.
    send_frame(1'b1, 10'h210, 1'b1);
    end_frame();
    ss_n = 1'b0; tick();
    mosi = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      mosi = i[0];
      tick();
    end
    ss_n = 1'b1;
    tick();
    check_bit("abort_miso", miso_m, 1'b0);
    check_bit("abort_flag_held", dut_m.rd_addr_seen_q, 1'b1);
`ifdef SPI_SLV_FRAME_ERR_EN
    check_bit("abort_frame_err_pulse", ferr_m, 1'b1);
    tick();
    check_bit("abort_frame_err_single", ferr_m, 1'b0);
`else
    tick();
`endif
    $display("[TB] partial frame aborted");

    // Abort on the edge that would capture the last bit.
    ss_n = 1'b0; tick();
    mosi = 1'b1; tick();
    for (int i = 9; i >= 1; i--) begin
      mosi = 1'b1;
      tick();
    end
    mosi = 1'b1; ss_n = 1'b1;
    tick();
    tick();
    check_bit("late_abort_flag_held", dut_m.rd_addr_seen_q, 1'b1);
    $display("[TB] last-bit abort done");

    // Flag held, so this read goes straight to READ_DATA.
    send_frame(1'b1, 10'h3C3, 1'b1);
    tick();
    check_bit("read_data_after_abort", dut_m.rd_addr_seen_q, 1'b0);
    reply(8'h5A);
    end_frame();

    // Reset during the reply.
    send_frame(1'b1, 10'h201, 1'b1);
    end_frame();
    send_frame(1'b1, 10'h301, 1'b1);
    tick();
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check_bit("rdtx_first_bit", miso_m, 1'b1);
    tick(); tick();
    rst = 1'b1; ss_n = 1'b1;
    tick();
    check_bit("rst_rdtx_miso", miso_m, 1'b0);
    check_bit("rst_rdtx_flag", dut_m.rd_addr_seen_q, 1'b0);
    rst = 1'b0;
    tick();
    send_frame(1'b1, 10'h2F0, 1'b1);
    tick();
    check_bit("post_reset_routes_read_add", dut_m.rd_addr_seen_q, 1'b1);
    end_frame();
    $display("[TB] reset during reply done");

    repeat (3) tick();
    check_vec("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
